// File: rtl/regfile_vector_lanes_vn.sv
// Vector register file: NUM_REGS registers of LANES x XLEN bits.
// Two combinational read ports with write-through bypass, one lane-masked
// write port, optional hardwired-zero register 0, and a one-register-per-cycle
// clear sweep that reports progress on clear_busy.
//
// Handshake: clear_start is a request sampled on the rising edge. It is
// accepted only in IDLE. clear_busy is high for exactly NUM_REGS cycles after
// it is accepted. clear_start is ignored while clear_busy is high. Writes
// presented while clear_start or clear_busy is high are dropped and do not
// bypass onto the read ports.
module regfile_vector_lanes_vn #(
  parameter int XLEN     = 32,
  parameter int LANES    = 4,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NUM_REGS),
  localparam int RW      = LANES * XLEN
) (
  input  logic          clock,
  input  logic          async_reset,
  input  logic          write_enable,
  input  logic [AW-1:0] write_addr,
  input  logic [RW-1:0] write_data,
  input  logic [LANES-1:0] write_mask,
  input  logic [AW-1:0] read_addr_1,
  input  logic [AW-1:0] read_addr_2,
  output logic [RW-1:0] read_data_1,
  output logic [RW-1:0] read_data_2,
  input  logic          clear_start,
  output logic          clear_busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] regs_q [NUM_REGS];

  logic          addr0_is_zero_reg;
  logic          write_commit;

  // Register 0 absorbs writes only when it is configured as hardwired zero.
  assign addr0_is_zero_reg = (ZERO_REG != 0) && (write_addr == '0);

  // A write lands only in IDLE and never in the cycle a sweep is requested.
  assign write_commit = write_enable && !clear_busy && !clear_start &&
                        !addr0_is_zero_reg;

  assign clear_busy = (state_q == ST_CLEAR);

  // Merge the in-flight write into a stored value lane by lane.
  function automatic logic [RW-1:0] lane_merge(
    input logic [RW-1:0]    old_val,
    input logic [RW-1:0]    new_val,
    input logic [LANES-1:0] mask
  );
    logic [RW-1:0] res;
    res = old_val;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        res[i*XLEN +: XLEN] = new_val[i*XLEN +: XLEN];
      end
    end
    return res;
  endfunction

  // FSM state and sweep counter register.
  always_ff @(posedge clock) begin
    if (async_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE waits for a request, CLEAR walks every index once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(NUM_REGS - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage: reset zeroes everything, the sweep zeroes one entry per cycle,
  // otherwise a committed write updates only its masked lanes.
  always_ff @(posedge clock) begin
    if (async_reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (state_q == ST_CLEAR) begin
      regs_q[cnt_q] <= '0;
    end else if (write_commit) begin
      regs_q[write_addr] <= lane_merge(regs_q[write_addr], write_data, write_mask);
    end
  end

  // Read port 1: stored value, forced zero for register 0, bypassed by a
  // committed write to the same index.
  always_comb begin
    read_data_1 = regs_q[read_addr_1];
    if ((ZERO_REG != 0) && (read_addr_1 == '0)) begin
      read_data_1 = '0;
    end
    if (write_commit && (read_addr_1 == write_addr)) begin
      read_data_1 = lane_merge(read_data_1, write_data, write_mask);
    end
  end

  // Read port 2: same structure as port 1, bypassing independently.
  always_comb begin
    read_data_2 = regs_q[read_addr_2];
    if ((ZERO_REG != 0) && (read_addr_2 == '0)) begin
      read_data_2 = '0;
    end
    if (write_commit && (read_addr_2 == write_addr)) begin
      read_data_2 = lane_merge(read_data_2, write_data, write_mask);
    end
  end

endmodule

// File: tb/tb_regfile_vector_lanes_vn.sv
// Directed bench for regfile_vector_lanes_vn with default parameters
// (4 lanes x 32 bits, 32 registers, hardwired-zero register 0).
module tb_regfile_vector_lanes_vn;

  localparam int W  = 128;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic          clock;
  logic          async_reset;
  logic          write_enable;
  logic [AW-1:0] write_addr;
  logic [W-1:0]  write_data;
  logic [3:0]    write_mask;
  logic [AW-1:0] read_addr_1;
  logic [AW-1:0] read_addr_2;
  logic [W-1:0]  read_data_1;
  logic [W-1:0]  read_data_2;
  logic          clear_start;
  logic          clear_busy;

  int checks_cnt;
  int errors_cnt;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  regfile_vector_lanes_vn dut (
    .clock        (clock),
    .async_reset  (async_reset),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_mask   (write_mask),
    .read_addr_1  (read_addr_1),
    .read_addr_2  (read_addr_2),
    .read_data_1  (read_data_1),
    .read_data_2  (read_data_2),
    .clear_start  (clear_start),
    .clear_busy   (clear_busy)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one rising edge; inputs are driven 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    write_enable = 1'b0;
    write_mask   = 4'h0;
    write_data   = '0;
    clear_start  = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [3:0] m);
    write_enable = 1'b1;
    write_addr   = a;
    write_data   = d;
    write_mask   = m;
    step();
    idle_inputs();
  endtask

  function automatic logic [W-1:0] splat(input logic [31:0] v);
    return {v, v, v, v};
  endfunction

  task automatic read1(input logic [AW-1:0] a, input string tag, input logic [W-1:0] exp);
    read_addr_1 = a;
    #1;
    check(tag, read_data_1, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] v_full;
    logic [W-1:0] v_part;
    int busy_cnt;

    checks_cnt  = 0;
    errors_cnt  = 0;
    async_reset = 1'b1;
    write_addr  = '0;
    read_addr_1 = '0;
    read_addr_2 = '0;
    idle_inputs();
    step();
    step();
    async_reset = 1'b0;
    #1;
    check("reset_busy", W'(clear_busy), W'(0));
    read1(5'd4, "reset_reg4", '0);

    // Full write, then read back; port 2 sees an untouched register.
    v_full = 128'hABCDE123_11111111_22222222_33333333;
    do_write(5'd4, v_full, 4'b1111);
    read_addr_2 = 5'd2;
    read1(5'd4, "full_write_rd1", v_full);
    check("untouched_rd2", read_data_2, '0);

    // Partial write with both ports bypassing the same address.
    v_part = 128'hABCDE123_FFFFFFFF_22222222_FFFFFFFF;
    read_addr_1  = 5'd4;
    read_addr_2  = 5'd4;
    write_enable = 1'b1;
    write_addr   = 5'd4;
    write_data   = {128{1'b1}};
    write_mask   = 4'b0101;
    #1;
    check("bypass_rd1", read_data_1, v_part);
    check("bypass_rd2", read_data_2, v_part);
    step();
    idle_inputs();
    #1;
    check("partial_stored", read_data_1, v_part);

    // Mask of zero is a no-op, including on the bypass path.
    write_enable = 1'b1;
    write_addr   = 5'd4;
    write_data   = '0;
    write_mask   = 4'b0000;
    #1;
    check("mask0_bypass", read_data_1, v_part);
    step();
    idle_inputs();
    #1;
    check("mask0_stored", read_data_1, v_part);

    // Register 0 is hardwired zero.
    read_addr_1  = 5'd0;
    write_enable = 1'b1;
    write_addr   = 5'd0;
    write_data   = {128{1'b1}};
    write_mask   = 4'hF;
    #1;
    check("zero_reg_same_cycle", read_data_1, '0);
    step();
    idle_inputs();
    #1;
    check("zero_reg_after", read_data_1, '0);

    // Fill registers 1..31 with their index in every lane.
    for (int r = 1; r < 32; r++) begin
      do_write(AW'(r), splat(32'(r)), 4'hF);
    end
    read1(5'd1, "fill_reg1", splat(32'd1));
    read1(5'd31, "fill_reg31", splat(32'd31));

    // Clear sweep with mid-sweep probes and dropped writes.
    clear_start = 1'b1;
    #1;
    check("busy_before_accept", W'(clear_busy), W'(0));
    step();
    clear_start = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 10) begin
        write_enable = 1'b1;
        write_addr   = 5'd20;
        write_data   = splat(32'hDEAD_BEEF);
        write_mask   = 4'hF;
        read_addr_1  = 5'd5;
        read_addr_2  = 5'd20;
        #1;
        check("mid_sweep_reg5", read_data_1, '0);
        check("mid_sweep_reg20_nobypass", read_data_2, splat(32'd20));
      end
      if (c == 11) begin
        write_addr = 5'd3;
        write_data = splat(32'h3333_3333);
        read_addr_1 = 5'd3;
        #1;
        check("mid_sweep_reg3_nobypass", read_data_1, '0);
      end
      if (c == 12) begin
        idle_inputs();
        read_addr_2 = 5'd20;
        #1;
        check("mid_sweep_reg20_kept", read_data_2, splat(32'd20));
      end
      if (clear_busy !== 1'b1) break;
      busy_cnt++;
      step();
    end
    idle_inputs();
    check("busy_cycles", W'(busy_cnt), W'(32));
    for (int r = 0; r < 32; r++) begin
      read1(AW'(r), $sformatf("after_sweep_reg%0d", r), '0);
    end

    // Reset during a sweep.
    do_write(5'd9, splat(32'h77), 4'hF);
    do_write(5'd20, splat(32'd20), 4'hF);
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int c = 0; c < 7; c++) step();
    async_reset = 1'b1;
    step();
    async_reset = 1'b0;
    #1;
    check("reset_mid_sweep_busy", W'(clear_busy), W'(0));
    read1(5'd9, "reset_mid_sweep_reg9", '0);
    read1(5'd20, "reset_mid_sweep_reg20", '0);
    do_write(5'd9, splat(32'h5A), 4'hF);
    read1(5'd9, "post_reset_write_reg9", splat(32'h5A));

    // clear_start and a write in the same IDLE cycle: write dropped.
    do_write(5'd6, splat(32'h66), 4'hF);
    clear_start  = 1'b1;
    write_enable = 1'b1;
    write_addr   = 5'd6;
    write_data   = {128{1'b1}};
    write_mask   = 4'hF;
    read_addr_1  = 5'd6;
    #1;
    check("start_write_nobypass", read_data_1, splat(32'h66));
    step();
    idle_inputs();
    #1;
    check("start_write_busy", W'(clear_busy), W'(1));
    check("start_write_dropped", read_data_1, splat(32'h66));
    for (int c = 0; c < 40; c++) begin
      if (clear_busy !== 1'b1) break;
      step();
    end
    check("start_write_sweep_done", W'(clear_busy), W'(0));
    read1(5'd6, "start_write_reg6_cleared", '0);

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
